master_serial_port: RTL and testbench
=====================================

# master_serial_port

Bus-master-side serializer that turns one parallel read/write request into the bit-serial address/data stream that the slave ports on the serial bus consume. It also deserializes the slave's read-data stream back into a parallel response. It sits between a bus master (CPU/test driver) and the serial bus, directly upstream of the slave port and slave memory. Each request is a single-beat transaction: address first, then data, LSB first.

## Interface
- ADDR_WIDTH, 12, address bits shifted per transaction
- DATA_WIDTH, 8, data bits per transaction
- TIMEOUT, 1024, max cycles to wait for first read bit (only with MASTER_PORT_TIMEOUT_EN)

- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  master request valid
- req_ready  out  1  port idle and accepting a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid on reads
- rsp_err  out  1  read timed out, valid with rsp_valid
- mwdata  out  1  serial address/write data to slave
- mmode  out  1  0 read, 1 write
- mvalid  out  1  mwdata valid
- sready  in  1  slave ready for transaction
- srdata  in  1  serial read data from slave
- svalid  in  1  srdata valid

## Operation
- States: IDLE, WAIT_RDY, ADDR, WDATA, RWAIT, RDATA, RESP.
- IDLE: req_ready=1. On req_valid, capture req_wr/addr/wdata into shift registers and go to WAIT_RDY.
- WAIT_RDY: mvalid=0. Stay until sready=1, then go to ADDR.
- ADDR: mvalid=1, mmode=captured req_wr, mwdata=addr[0], shifting right each cycle for exactly ADDR_WIDTH cycles.
  - After the last address bit: write goes to WDATA, read goes to RWAIT.
- WDATA: mvalid=1, mmode=1, DATA_WIDTH cycles of wdata LSB first, then RESP. mvalid has no gap between address and data.
- RWAIT: mvalid=0. The first cycle with svalid=1 samples srdata as bit 0 and enters RDATA.
- RDATA: each svalid=1 cycle shifts srdata in at the MSB end of the read shift register (LSB-first assembly). An svalid=0 cycle pauses without losing bits. After DATA_WIDTH bits total, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata holds its value until the next read response; writes leave it unchanged.
- Bit counter width is $clog2(max(ADDR_WIDTH,DATA_WIDTH))+1. It is cleared on every state entry.
- Inputs sready/svalid/srdata are sampled only in the states listed above; they are ignored elsewhere.

## Timing
- Reset values: req_ready=0 during reset and 1 after, rsp_valid=0, rsp_rdata=0, rsp_err=0, mwdata=0, mmode=0, mvalid=0, state=IDLE.
- All outputs are registered. mvalid/mwdata for address bit 0 appear the cycle after sready is sampled high.
- Write latency with sready already high: acceptance plus 1 + ADDR_WIDTH + DATA_WIDTH + 1 cycles to rsp_valid (22 for defaults).
- Read latency: acceptance plus 1 + ADDR_WIDTH, plus the slave latency, plus DATA_WIDTH svalid cycles, plus 1.
- req_ready is low from the cycle after acceptance until the cycle after rsp_valid. A back-to-back request is accepted in the first IDLE cycle.
- Reset mid-transaction aborts immediately: all outputs go to reset values, no rsp_valid is issued, and the partial bus transfer is dropped.
- sready dropping mid-ADDR/WDATA is ignored: the stream completes.

## Configuration
- MASTER_PORT_TIMEOUT_EN defined:
  - A counter runs in RWAIT.
  - After TIMEOUT cycles without svalid, go to RESP with rsp_err=1 and rsp_rdata=0.
  - rsp_err=0 on every other response.
- Not defined:
  - RWAIT waits indefinitely.
  - rsp_err is tied to 0.
  - No counter is synthesized.

## Structure
- Shared package master_port_pkg: state enum type, default width constants, and the bit-counter width function.
- One sub-module, serial_shift_reg: a parameterized load/shift-out/shift-in register. Instantiate it once for address+write data and once for read data.

## Test plan
- Write, ADDR=0x5A3, DATA=0xC7, sready=1 → mmode=1, mvalid high for 20 cycles, mwdata=1,1,0,0,0,1,0,1,1,0,1,0 then 1,1,1,0,0,0,1,1, then one rsp_valid pulse with rsp_err=0.
- Read, ADDR=0x010, slave returns 0x3C after 3 idle cycles → 12 address bits with mmode=0, then rsp_valid with rsp_rdata=0x3C.
- Read with svalid gapped (bits 0-3, two idle cycles, bits 4-7) of 0xA5 → rsp_rdata=0xA5, no lost or duplicated bits.
- sready held low for 10 cycles after request → mvalid stays 0 and req_ready=0 throughout; streaming starts the cycle after sready rises.
- Reset asserted on the 5th address bit → next cycle mvalid=0 and state IDLE, no rsp_valid; a following write completes normally.
- MASTER_PORT_TIMEOUT_EN with TIMEOUT=16, read with no svalid → rsp_valid 16 cycles after entering RWAIT, rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/master_port_pkg.sv
// rtl/master_port_pkg.sv - shared types, default widths and counter sizing for the master serial port
package master_port_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TIMEOUT    = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_ADDR,
        ST_WDATA,
        ST_RWAIT,
        ST_RDATA,
        ST_RESP
    } state_t;

    // Bit counter must reach the larger of the two stream lengths.
    function automatic int cnt_width(input int aw, input int dw);
        return $clog2((aw > dw) ? aw : dw) + 1;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// rtl/serial_shift_reg.sv - parameterized load / right-shift register (shift-out at LSB, shift-in at MSB)
//
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   i_load       parallel load of i_load_data (wins over i_shift)
//   i_load_data  value to load
//   i_shift      shift right one place, i_sin enters at the MSB
//   i_sin        serial input bit
//   o_q          register contents; o_q[0] is the next bit to shift out
module serial_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[W-1:1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/master_serial_port.sv
// rtl/master_serial_port.sv - bus-master serializer: parallel request to LSB-first serial addr/data, serial read data back to parallel
//
// Optional feature macro: MASTER_PORT_TIMEOUT_EN (read wait timeout with rsp_err).
//
// Ports:
//   clk, rstn                        clock, synchronous active-low reset
//   req_valid/req_ready              request handshake (ready only while idle)
//   req_wr, req_addr, req_wdata      request contents (1 = write)
//   rsp_valid, rsp_rdata, rsp_err    one-cycle completion pulse with read data / timeout flag
//   mwdata, mmode, mvalid            serial stream to slave (mmode 1 = write)
//   sready                           slave ready to start a transaction
//   srdata, svalid                   serial read data from slave
//
// DATA_WIDTH must be at least 2.
module master_serial_port
    import master_port_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mwdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  sready,
    input  logic                  srdata,
    input  logic                  svalid
);

    localparam int CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int SW = ADDR_WIDTH + DATA_WIDTH;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_wr;
    logic                  r_req_ready, r_rsp_valid, r_mvalid, r_mmode;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_load, w_tx_shift, w_rd_shift, w_counting;
    logic [SW-1:0]         w_tx_q;
    logic [DATA_WIDTH-1:0] w_rd_q, w_rd_next;
    logic                  w_unused;

    assign w_load     = (r_state == ST_IDLE) && req_valid;
    assign w_tx_shift = (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign w_rd_shift = ((r_state == ST_RWAIT) || (r_state == ST_RDATA)) && svalid;
    assign w_counting = w_tx_shift || ((r_state == ST_RDATA) && svalid);
    // Value the read register will hold once the current bit is shifted in.
    assign w_rd_next  = {srdata, w_rd_q[DATA_WIDTH-1:1]};
    assign w_unused   = ^{w_tx_q[SW-1:1], w_rd_q[0]};

    // Address and write data share one register: address drains first, data follows with no gap.
    serial_shift_reg #(.W(SW)) u_tx_sr (
        .clk         (clk),
        .rstn        (rstn),
        .i_load      (w_load),
        .i_load_data ({req_wdata, req_addr}),
        .i_shift     (w_tx_shift),
        .i_sin       (1'b0),
        .o_q         (w_tx_q)
    );

    serial_shift_reg #(.W(DATA_WIDTH)) u_rd_sr (
        .clk         (clk),
        .rstn        (rstn),
        .i_load      (w_load),
        .i_load_data ('0),
        .i_shift     (w_rd_shift),
        .i_sin       (srdata),
        .o_q         (w_rd_q)
    );

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] r_to_cnt;
    logic          w_to_expired;
    logic          r_rsp_err;

    assign w_to_expired = (r_state == ST_RWAIT) && (r_to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rstn || (r_state != ST_RWAIT)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Leaving RWAIT straight to RESP can only happen on expiry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rsp_err <= 1'b0;
        end else if ((w_next == ST_RESP) && (r_state != ST_RESP)) begin
            r_rsp_err <= (r_state == ST_RWAIT);
        end
    end

    assign rsp_err = r_rsp_err;
`else
    localparam int unused_timeout = TIMEOUT;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (req_valid) w_next = ST_WAIT_RDY;
            ST_WAIT_RDY: if (sready) w_next = ST_ADDR;
            ST_ADDR:     if (r_cnt == CW'(ADDR_WIDTH - 1)) w_next = r_wr ? ST_WDATA : ST_RWAIT;
            ST_WDATA:    if (r_cnt == CW'(DATA_WIDTH - 1)) w_next = ST_RESP;
            ST_RWAIT: begin
                if (svalid) begin
                    w_next = ST_RDATA;
`ifdef MASTER_PORT_TIMEOUT_EN
                end else if (w_to_expired) begin
                    w_next = ST_RESP;
`endif
                end
            end
            // Bit 0 arrived in RWAIT, so RDATA ends on the (DATA_WIDTH-1)th bit it sees.
            ST_RDATA:    if (svalid && (r_cnt == CW'(DATA_WIDTH - 2))) w_next = ST_RESP;
            ST_RESP:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_mvalid    <= 1'b0;
            r_mmode     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load) begin
                r_wr <= req_wr;
            end
            // Outputs are registered from the next state so they align with it.
            r_req_ready <= (w_next == ST_IDLE);
            r_rsp_valid <= (w_next == ST_RESP);
            r_mvalid    <= (w_next == ST_ADDR) || (w_next == ST_WDATA);
            r_mmode     <= ((w_next == ST_ADDR) && r_wr) || (w_next == ST_WDATA);
            if ((r_state == ST_RDATA) && (w_next == ST_RESP)) begin
                r_rsp_rdata <= w_rd_next;
            end else if ((r_state == ST_RWAIT) && (w_next == ST_RESP)) begin
                r_rsp_rdata <= '0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign mvalid    = r_mvalid;
    assign mmode     = r_mmode;
    // Keep the serial data line quiet whenever no bit is being presented.
    assign mwdata    = r_mvalid & w_tx_q[0];

endmodule

// File: tb/tb_master_serial_port.sv
// tb/tb_master_serial_port.sv - directed self-checking bench for master_serial_port
module tb_master_serial_port;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [11:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        mwdata, mmode, mvalid;
    logic        sready = 1'b0;
    logic        srdata = 1'b0;
    logic        svalid = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  last_rdata = 8'h00;

    always #5 clk = ~clk;

    master_serial_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mwdata    (mwdata),
        .mmode     (mmode),
        .mvalid    (mvalid),
        .sready    (sready),
        .srdata    (srdata),
        .svalid    (svalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected stream is the hand-listed bit sequence, first element first on the wire.
    task automatic do_write(input string tag, input logic [11:0] a, input logic [7:0] d,
                            input logic [19:0] seq, input int delay, input bit drop);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
        sready = (delay == 0);
        chk({tag, " ready_before"}, req_ready, 1);
        tick();
        req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        chk({tag, " ready_low"}, req_ready, 0);
        for (int k = 0; k < delay; k++) begin
            chk({tag, " wait_mvalid"}, mvalid, 0);
            chk({tag, " wait_ready"}, req_ready, 0);
            tick();
        end
        sready = 1'b1;
        chk({tag, " pre_mvalid"}, mvalid, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("%s mvalid[%0d]", tag, i), mvalid, 1);
            chk($sformatf("%s mmode[%0d]", tag, i), mmode, 1);
            chk($sformatf("%s mwdata[%0d]", tag, i), mwdata, seq[19-i]);
            chk($sformatf("%s no_rsp[%0d]", tag, i), rsp_valid, 0);
            if (drop && i == 6) sready = 1'b0;
            tick();
        end
        sready = 1'b1;
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_err"}, rsp_err, 0);
        chk({tag, " rsp_rdata_held"}, rsp_rdata, last_rdata);
        chk({tag, " mvalid_end"}, mvalid, 0);
        tick();
        chk({tag, " rsp_pulse"}, rsp_valid, 0);
        chk({tag, " ready_back"}, req_ready, 1);
    endtask

    task automatic do_read(input string tag, input logic [11:0] a, input logic [7:0] d,
                           input int pre, input int gap_at, input int gap_len);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = 8'hFF;
        sready = 1'b1;
        chk({tag, " ready_before"}, req_ready, 1);
        tick();
        req_valid = 1'b0; req_addr = '0;
        chk({tag, " ready_low"}, req_ready, 0);
        chk({tag, " wait_mvalid"}, mvalid, 0);
        tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s mvalid[%0d]", tag, i), mvalid, 1);
            chk($sformatf("%s mmode[%0d]", tag, i), mmode, 0);
            chk($sformatf("%s mwdata[%0d]", tag, i), mwdata, a[i]);
            tick();
        end
        chk({tag, " rwait_mvalid"}, mvalid, 0);
        for (int k = 0; k < pre; k++) begin
            chk({tag, " slave_lat"}, rsp_valid, 0);
            tick();
        end
        for (int b = 0; b < 8; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    svalid = 1'b0; srdata = 1'b1;
                    chk({tag, " gap"}, rsp_valid, 0);
                    tick();
                end
            end
            svalid = 1'b1; srdata = d[b];
            chk($sformatf("%s bit_wait[%0d]", tag, b), rsp_valid, 0);
            tick();
        end
        svalid = 1'b0; srdata = 1'b0;
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_rdata"}, rsp_rdata, d);
        chk({tag, " rsp_err"}, rsp_err, 0);
        last_rdata = d;
        tick();
        chk({tag, " rsp_pulse"}, rsp_valid, 0);
        chk({tag, " rdata_hold"}, rsp_rdata, d);
        chk({tag, " ready_back"}, req_ready, 1);
    endtask

    initial begin
        logic [11:0] ra;

        // Reset state
        tick(); tick(); tick();
        chk("rst req_ready", req_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst mvalid", mvalid, 0);
        chk("rst mwdata", mwdata, 0);
        chk("rst mmode", mmode, 0);
        rstn = 1'b1;
        tick();
        chk("post_rst req_ready", req_ready, 1);

        // Write 0x5A3 / 0xC7: 1,1,0,0,0,1,0,1,1,0,1,0 then 1,1,1,0,0,0,1,1
        do_write("wr1", 12'h5A3, 8'hC7, 20'b1100_0101_1010_1110_0011, 0, 1'b0);

        // Read 0x010, slave returns 0x3C after 3 idle cycles
        do_read("rd1", 12'h010, 8'h3C, 3, 8, 0);

        // Read 0x7FF with 0xA5 gapped after bit 3 by two idle cycles
        do_read("rd2", 12'h7FF, 8'hA5, 0, 4, 2);

        // Write 0x0F0 / 0x3E with sready low 10 cycles, then sready drops mid-stream
        // 0x0F0 LSB first: 0,0,0,0,1,1,1,1,0,0,0,0 ; 0x3E: 0,1,1,1,1,1,0,0
        do_write("wr2", 12'h0F0, 8'h3E, 20'b0000_1111_0000_0111_1100, 10, 1'b1);

        // Reset on the 5th address bit of a write to 0x9B6
        ra = 12'h9B6;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = ra; req_wdata = 8'h55; sready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("abort bit4 mvalid", mvalid, 1);
        chk("abort bit4 mwdata", mwdata, ra[4]);
        rstn = 1'b0;
        tick();
        chk("abort mvalid", mvalid, 0);
        chk("abort mwdata", mwdata, 0);
        chk("abort req_ready", req_ready, 0);
        chk("abort rsp_valid", rsp_valid, 0);
        chk("abort rsp_rdata", rsp_rdata, 0);
        last_rdata = 8'h00;
        rstn = 1'b1;
        tick();
        chk("abort idle req_ready", req_ready, 1);
        chk("abort idle rsp_valid", rsp_valid, 0);
        chk("abort idle mvalid", mvalid, 0);
        tick();
        chk("abort quiet rsp_valid", rsp_valid, 0);

        // Write 0xABC / 0x81 after the abort
        // 0xABC LSB first: 0,0,1,1,1,1,0,1,0,1,0,1 ; 0x81: 1,0,0,0,0,0,0,1
        do_write("wr3", 12'hABC, 8'h81, 20'b0011_1101_0101_1000_0001, 0, 1'b0);

`ifdef MASTER_PORT_TIMEOUT_EN
        // Read with no svalid: response 16 cycles after entering RWAIT
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 12'h123; sready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 12; i++) tick();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("to wait[%0d]", k), rsp_valid, 0);
            tick();
        end
        chk("to rsp_valid", rsp_valid, 1);
        chk("to rsp_err", rsp_err, 1);
        chk("to rsp_rdata", rsp_rdata, 0);
        tick();
        chk("to rsp_pulse", rsp_valid, 0);
        do_read("rd3", 12'h456, 8'h5C, 2, 8, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
